// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the D-stage decoder / pipeline registers and hazard_ctrl.
// The pipeline side uses the master modport; hazard_ctrl uses the slave modport.
interface hazard_ctrl_if;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic       wr_d;
    logic [4:0] dst_d;
    logic [1:0] tnew_d;
    logic       md_use_d;
    logic       md_start_e;
    logic       md_div_e;
    logic       en_pc;
    logic       en_d;
    logic       flush_e;
    logic [1:0] fwd_rs_d;
    logic [1:0] fwd_rt_d;
    logic [1:0] fwd_rs_e;
    logic [1:0] fwd_rt_e;
    logic       md_busy;

    modport slave (
        input  rs_d, rt_d, tuse_rs, tuse_rt, wr_d, dst_d, tnew_d,
        input  md_use_d, md_start_e, md_div_e,
        output en_pc, en_d, flush_e,
        output fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
    );

    modport master (
        output rs_d, rt_d, tuse_rs, tuse_rt, wr_d, dst_d, tnew_d,
        output md_use_d, md_start_e, md_div_e,
        input  en_pc, en_d, flush_e,
        input  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding control for the 5-stage MIPS pipeline with a mult/div busy window.
// Define HAZARD_FWD_EN for Tuse/Tnew forwarding; otherwise any in-flight writer of a source stalls.
module hazard_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);
    typedef struct packed {
        logic       wr;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
    } sb_e_t;

    typedef struct packed {
        logic       wr;
        logic [4:0] dst;
        logic [1:0] tnew;
    } sb_m_t;

    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    sb_e_t      sb_e_reg, sb_e_next;
    sb_m_t      sb_m_reg, sb_m_next;
    logic       w_wr_reg, w_wr_next;
    logic [4:0] w_dst_reg, w_dst_next;
    logic [3:0] md_cnt_reg, md_cnt_next;

    logic [4:0] src_d [2];
    logic [1:0] tuse_d [2];
    logic [1:0] fwd_d [2];
    logic [1:0] fwd_e [2];
    logic [1:0] stall_src;
    logic       md_busy;
    logic       stall_md;
    logic       stall;

    // $0 is hardwired, so a write to it never creates a dependence.
    function automatic logic hit(input logic wr, input logic [4:0] dst, input logic [4:0] r);
        return wr && (dst == r) && (r != 5'd0);
    endfunction

    assign src_d[0]  = hz.rs_d;
    assign src_d[1]  = hz.rt_d;
    assign tuse_d[0] = hz.tuse_rs;
    assign tuse_d[1] = hz.tuse_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
`ifdef HAZARD_FWD_EN
            logic [4:0] src_e;
            assign src_e = (gi == 0) ? sb_e_reg.rs : sb_e_reg.rt;
            assign stall_src[gi] =
                (hit(sb_e_reg.wr, sb_e_reg.dst, src_d[gi]) && (sb_e_reg.tnew > tuse_d[gi])) ||
                (hit(sb_m_reg.wr, sb_m_reg.dst, src_d[gi]) && (sb_m_reg.tnew > tuse_d[gi]));
            assign fwd_d[gi] =
                (hit(sb_m_reg.wr, sb_m_reg.dst, src_d[gi]) && (sb_m_reg.tnew == 2'd0)) ? 2'd1 :
                hit(w_wr_reg, w_dst_reg, src_d[gi]) ? 2'd2 : 2'd0;
            assign fwd_e[gi] =
                (hit(sb_m_reg.wr, sb_m_reg.dst, src_e) && (sb_m_reg.tnew == 2'd0)) ? 2'd1 :
                hit(w_wr_reg, w_dst_reg, src_e) ? 2'd2 : 2'd0;
`else
            // Without forwarding the value is only safe once the writer has left W.
            assign stall_src[gi] = (tuse_d[gi] != 2'd3) &&
                (hit(sb_e_reg.wr, sb_e_reg.dst, src_d[gi]) ||
                 hit(sb_m_reg.wr, sb_m_reg.dst, src_d[gi]) ||
                 hit(w_wr_reg, w_dst_reg, src_d[gi]));
            assign fwd_d[gi] = 2'd0;
            assign fwd_e[gi] = 2'd0;
`endif
        end
    endgenerate

`ifndef HAZARD_FWD_EN
    logic unused_sb;
    assign unused_sb = ^{sb_e_reg.rs, sb_e_reg.rt, sb_m_reg.tnew};
`endif

    assign md_busy  = (md_cnt_reg != 4'd0);
    assign stall_md = hz.md_use_d && (md_busy || hz.md_start_e);
    assign stall    = (|stall_src) || stall_md;

    assign hz.en_pc    = ~stall;
    assign hz.en_d     = ~stall;
    assign hz.flush_e  = stall;
    assign hz.fwd_rs_d = fwd_d[0];
    assign hz.fwd_rt_d = fwd_d[1];
    assign hz.fwd_rs_e = fwd_e[0];
    assign hz.fwd_rt_e = fwd_e[1];
    assign hz.md_busy  = md_busy;

    always_comb begin
        sb_e_next = '0;
        if (!stall) begin
            sb_e_next = '{wr: hz.wr_d, dst: hz.dst_d, tnew: hz.tnew_d, rs: hz.rs_d, rt: hz.rt_d};
        end
        sb_m_next.wr   = sb_e_reg.wr;
        sb_m_next.dst  = sb_e_reg.dst;
        sb_m_next.tnew = (sb_e_reg.tnew == 2'd0) ? 2'd0 : sb_e_reg.tnew - 2'd1;
        w_wr_next      = sb_m_reg.wr;
        w_dst_next     = sb_m_reg.dst;

        md_cnt_next = md_cnt_reg;
        if (hz.md_start_e) begin
            md_cnt_next = hz.md_div_e ? DIV_LD : MULT_LD;
        end else if (md_busy) begin
            md_cnt_next = md_cnt_reg - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_e_reg   <= '0;
            sb_m_reg   <= '0;
            w_wr_reg   <= 1'b0;
            w_dst_reg  <= 5'd0;
            md_cnt_reg <= 4'd0;
        end else begin
            sb_e_reg   <= sb_e_next;
            sb_m_reg   <= sb_m_next;
            w_wr_reg   <= w_wr_next;
            w_dst_reg  <= w_dst_next;
            md_cnt_reg <= md_cnt_next;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl: a timestamped instruction-history model predicts
// each cycle's controls into a queue, and a negedge monitor pops and compares.
module tb_hazard_ctrl;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
`ifdef HAZARD_FWD_EN
    localparam int LU_STALLS = 1, BR_STALLS = 1, SW_STALLS = 0, ADD_STALLS = 0;
`else
    localparam int LU_STALLS = 3, BR_STALLS = 3, SW_STALLS = 3, ADD_STALLS = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hz)
    );

    typedef struct {
        bit [4:0] rs, rt;
        bit [1:0] tuse_rs, tuse_rt;
        bit       wr;
        bit [4:0] dst;
        bit [1:0] tnew;
        bit       md_use, md_start, md_div;
    } d_t;

    typedef struct {
        bit wr;
        int dst, tnew, rs, rt;
    } rec_t;

    typedef struct {
        bit stall;
        int frd, frt, fre, frte;
        bit busy;
    } exp_t;

    rec_t hist[$];          // hist[age]: age 0 = in E, 1 = in M, 2 = in W
    exp_t expq[$];
    int   cyc = 0;
    int   busy_until = -1;  // last cycle index during which the mult/div unit is occupied
    d_t   last_d;
    bit   last_stall = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   txn = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic rec_t at(input int age);
        rec_t r = '{default: 0};
        if (age < hist.size()) r = hist[age];
        return r;
    endfunction

    function automatic bit writes(input int age, input int r);
        rec_t p = at(age);
        return p.wr && (p.dst == r) && (r != 0);
    endfunction

    // Cycles still needed before the producer's result exists, given how far it has travelled.
    function automatic int remaining(input int age);
        rec_t p = at(age);
        return (p.tnew > age) ? p.tnew - age : 0;
    endfunction

    function automatic bit blocks(input int r, input int tuse);
`ifdef HAZARD_FWD_EN
        return (writes(0, r) && remaining(0) > tuse) || (writes(1, r) && remaining(1) > tuse);
`else
        return (tuse != 3) && (writes(0, r) || writes(1, r) || writes(2, r));
`endif
    endfunction

    function automatic int source(input int r);
`ifdef HAZARD_FWD_EN
        if (writes(1, r) && remaining(1) == 0) return 1;
        if (writes(2, r)) return 2;
`endif
        return 0;
    endfunction

    function automatic exp_t predict(input d_t d);
        exp_t e;
        e.busy  = (cyc <= busy_until);
        e.stall = blocks(d.rs, d.tuse_rs) || blocks(d.rt, d.tuse_rt) ||
                  (d.md_use && (e.busy || d.md_start));
        e.frd   = source(d.rs);
        e.frt   = source(d.rt);
        e.fre   = source(at(0).rs);
        e.frte  = source(at(0).rt);
        return e;
    endfunction

    function automatic void advance();
        rec_t n = '{default: 0};
        if (!last_stall) n = '{wr: last_d.wr, dst: last_d.dst, tnew: last_d.tnew, rs: last_d.rs, rt: last_d.rt};
        hist.push_front(n);
        if (hist.size() > 3) void'(hist.pop_back());
        if (last_d.md_start) busy_until = cyc + (last_d.md_div ? DIV_N : MULT_N);
        cyc++;
    endfunction

    function automatic d_t idle();
        d_t d = '{default: 0};
        d.tuse_rs = 2'd3;
        d.tuse_rt = 2'd3;
        return d;
    endfunction

    function automatic d_t rand_d();
        d_t d;
        d.rs       = 5'($urandom_range(0, 7));
        d.rt       = 5'($urandom_range(0, 7));
        d.tuse_rs  = 2'($urandom_range(0, 3));
        d.tuse_rt  = 2'($urandom_range(0, 3));
        d.wr       = 1'($urandom_range(0, 1));
        d.dst      = 5'($urandom_range(0, 7));
        d.tnew     = 2'($urandom_range(0, 2));
        d.md_use   = ($urandom_range(0, 7) == 0);
        d.md_div   = 1'($urandom_range(0, 1));
        d.md_start = (cyc > busy_until) && ($urandom_range(0, 11) == 0);
        return d;
    endfunction

    // Move to just after the next rising edge; optionally assert reset for this cycle.
    task automatic tick(input bit rst_assert);
        @(posedge clk);
        if (rst_n) advance();
        #1;
        rst_n = !rst_assert;
        if (rst_assert) begin
            hist.delete();
            busy_until = -1;
        end
    endtask

    task automatic apply(input d_t d);
        exp_t e;
        hz.rs_d = d.rs;          hz.rt_d = d.rt;
        hz.tuse_rs = d.tuse_rs;  hz.tuse_rt = d.tuse_rt;
        hz.wr_d = d.wr;          hz.dst_d = d.dst;      hz.tnew_d = d.tnew;
        hz.md_use_d = d.md_use;  hz.md_start_e = d.md_start; hz.md_div_e = d.md_div;
        e = predict(d);
        expq.push_back(e);
        last_d     = d;
        last_stall = e.stall;
    endtask

    task automatic step(input d_t d);
        tick(1'b0);
        apply(d);
    endtask

    // Present an instruction in D until it is accepted; n = number of stalled cycles.
    task automatic issue(input d_t d, output int n);
        n = 0;
        step(d);
        while (last_stall && n < 30) begin
            n++;
            step(d);
        end
    endtask

    task automatic drain_pipe();
        for (int i = 0; i < 4; i++) step(idle());
    endtask

    function automatic d_t op(input int rs, input int tuse_rs, input int rt, input int tuse_rt,
                              input bit wr, input int dst, input int tnew);
        d_t d = idle();
        d.rs = 5'(rs);  d.tuse_rs = 2'(tuse_rs);
        d.rt = 5'(rt);  d.tuse_rt = 2'(tuse_rt);
        d.wr = wr;      d.dst = 5'(dst);  d.tnew = 2'(tnew);
        return d;
    endfunction

    // Monitor: one comparison set per presented cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("en_pc", int'(hz.en_pc), int'(!e.stall));
                chk("en_d", int'(hz.en_d), int'(!e.stall));
                chk("flush_e", int'(hz.flush_e), int'(e.stall));
                chk("fwd_rs_d", int'(hz.fwd_rs_d), e.frd);
                chk("fwd_rt_d", int'(hz.fwd_rt_d), e.frt);
                chk("fwd_rs_e", int'(hz.fwd_rs_e), e.fre);
                chk("fwd_rt_e", int'(hz.fwd_rt_e), e.frte);
                chk("md_busy", int'(hz.md_busy), int'(e.busy));
                $display("txn %0d: rst_n=%0b stall=%0b fwd_d=%0d/%0d fwd_e=%0d/%0d busy=%0b",
                         txn, rst_n, e.stall, e.frd, e.frt, e.fre, e.frte, e.busy);
                txn++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, s0;
        d_t d;
        apply(idle());
        void'(expq.pop_front());

        // Reset held with random inputs; mult/div start kept low.
        for (int i = 0; i < 5; i++) begin
            tick(1'b1);
            d = rand_d();
            d.md_start = 1'b0;
            apply(d);
        end
        for (int i = 0; i < 3; i++) step(idle());

        // Load-use, then the add sits in E with the load in W.
        issue(op(0, 3, 0, 3, 1, 8, 2), n);
        issue(op(8, 1, 0, 3, 1, 10, 1), n);
        chk("loaduse_stalls", n, LU_STALLS);
        drain_pipe();

        issue(op(0, 3, 0, 3, 1, 9, 1), n);
        issue(op(9, 0, 0, 3, 0, 0, 0), n);
        chk("alu_branch_stalls", n, BR_STALLS);
        drain_pipe();

        issue(op(0, 3, 0, 3, 1, 9, 1), n);
        issue(op(0, 1, 9, 2, 0, 0, 0), n);
        chk("alu_sw_stalls", n, SW_STALLS);
        drain_pipe();

        // Two writers of $5 in flight: the younger one (M) must win.
        issue(op(0, 3, 0, 3, 1, 5, 1), n);
        issue(op(0, 3, 0, 3, 1, 5, 1), n);
        issue(idle(), n);
        issue(op(5, 1, 0, 3, 0, 0, 0), n);
        drain_pipe();

        issue(op(0, 3, 0, 3, 1, 0, 2), n);
        issue(op(0, 0, 0, 0, 0, 0, 0), n);
        chk("zero_reg_stalls", n, 0);
        drain_pipe();

        issue(op(0, 3, 0, 3, 1, 3, 1), n);
        issue(op(3, 1, 0, 3, 1, 4, 1), n);
        chk("alu_alu_stalls", n, ADD_STALLS);
        drain_pipe();

        // div starts in E while mflo waits in D.
        d = op(0, 3, 0, 3, 1, 12, 1);
        d.md_use = 1'b1;
        d.md_start = 1'b1;
        d.md_div = 1'b1;
        step(d);
        s0 = int'(last_stall);
        d.md_start = 1'b0;
        issue(d, n);
        chk("div_mflo_stalls", s0 + n, 11);
        drain_pipe();

        // Reset pulse four cycles into a divide clears busy immediately.
        d = idle();
        d.md_start = 1'b1;
        d.md_div = 1'b1;
        step(d);
        for (int i = 0; i < 3; i++) step(idle());
        tick(1'b1);
        apply(idle());
        #1;
        chk("rst_mid_div_busy", int'(hz.md_busy), 0);
        step(idle());
        drain_pipe();

        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 63) == 0);
            apply(rand_d());
        end
        drain_pipe();

        for (int i = 0; i < 10 && expq.size() != 0; i++) @(negedge clk);
        if (expq.size() != 0) chk("scoreboard_drain", expq.size(), 0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
